vsfx_wb: RTL and testbench
==========================

// Module: vsfx_wb
// PURPOSE
//  Writeback stage directly downstream of the vsfx top level. Captures each vsfx result
//  (vrt_en/vrt/sat/cr6) with its target VR number and queues it in a small FIFO.
//  Drains the FIFO to the VR file write port over a valid/ready handshake.
//  Keeps the sticky VSCR[SAT] bit and the CR6 field.
// PARAMETERS
//  DEPTH   4    FIFO entries; power of 2, >=2
//  AW      2    log2(DEPTH); pointer width
// PORTS
//  clk          in   1    clock; all state changes on rising edge
//  rst          in   1    synchronous, active-high reset
//  vrt_en       in   1    vsfx result valid this cycle
//  vrt          in   128  vsfx result data
//  vrt_addr     in   5    target VR number, aligned with vrt_en
//  sat          in   1    vsfx saturation flag, qualified by vrt_en
//  cr6          in   4    vsfx CR6 value, qualified by vrt_en
//  cr6_en       in   1    record form: CR6 update requested, qualified by vrt_en
//  in_ready     out  1    =!full; upstream drives vsfx en low while 0
//  wb_valid     out  1    VR file write request
//  wb_addr      out  5    VR file write address
//  wb_data      out  128  VR file write data
//  wb_ready     in   1    VR file accepts the write this cycle
//  vscr_wr_en   in   1    mtvscr: overwrite SAT
//  vscr_wr_sat  in   1    SAT value written by mtvscr
//  vscr_sat     out  1    sticky VSCR[SAT]
//  cr6_out      out  4    architected CR6 field
//  ovf          out  1    sticky: push attempted while full (diagnostic)
// BEHAVIOUR
//  Reset: rd_ptr=wr_ptr=0, count=0, wb_valid=0, wb_addr=0, wb_data=0, in_ready=1,
//   vscr_sat=0, cr6_out=0, ovf=0. Reset wins over every other event in the same cycle.
//  push = vrt_en & in_ready. Writes {vrt_addr,vrt} to mem[wr_ptr]; wr_ptr+1 wraps mod DEPTH.
//  pop = wb_valid & wb_ready. rd_ptr+1 wraps mod DEPTH.
//  wb_valid = (count!=0). wb_addr and wb_data = mem[rd_ptr].
//  Outputs are held stable while wb_valid=1 and wb_ready=0.
//  Latency: a push in cycle N is presented at the head in cycle N+1 at the earliest.
//  count update:
//   push only  -> +1
//   pop only   -> -1
//   both       -> unchanged (legal whenever 0<count<DEPTH)
//  full = (count==DEPTH), computed from the registered count.
//   When full, push is refused even if a pop occurs in the same cycle.
//   in_ready returns to 1 the cycle after that pop.
//  vrt_en=1 with in_ready=0: result dropped, no state change except ovf<=1.
//   ovf clears only on rst.
//  Empty: wb_valid=0; wb_ready is ignored; no pointer motion.
//  Entries drain strictly in FIFO order. No reordering. Back-to-back same-address writes are kept.
//  SAT and CR6 update at push time, not at writeback.
//   vscr_sat next = (vscr_wr_en ? vscr_wr_sat : vscr_sat) | (push & sat).
//   Same-cycle mtvscr clear plus saturating push -> 1.
//  cr6_out <= cr6 when push & cr6_en; otherwise held.
//  sat/cr6/cr6_en from a refused vrt_en are ignored.
// CONFIGURATION
//  VSFX_WB_BYPASS_EN defined:
//   - When count==0 and vrt_en=1, the incoming result drives wb_valid/wb_addr/wb_data
//     combinationally in the same cycle.
//   - If wb_ready=1 it is consumed and never enters the FIFO (count stays 0).
//   - Otherwise it is pushed as normal.
//   - SAT/CR6 rules unchanged.
//  Undefined: registered path only; minimum latency is 1 cycle; wb_* depend only on state.
// TESTING
//  T1 reset: rst=1 for 2 cycles with vrt_en=1 -> all outputs at reset values; count=0 after release.
//  T2 ordering: push 0x11..11 to VR3, 0x22..22 to VR7, 0x33..33 to VR3; wb_ready=1
//     -> writes (3,0x11..),(7,0x22..),(3,0x33..) in that order, then wb_valid=0.
//  T3 full/ovf: wb_ready=0, 5 pushes -> in_ready=0 after the 4th; 5th dropped; ovf=1.
//     Then pop+push in the same cycle -> push refused; in_ready=1 on the next cycle.
//     Drain returns the first 4 entries.
//  T4 wrap/concurrent: 10 cycles of continuous push with wb_ready=1 -> count never exceeds 1;
//     pointers wrap; data matches.
//  T5 SAT: push sat=1 -> vscr_sat=1. vscr_wr_en=1,vscr_wr_sat=0 alone -> 0.
//     Same cycle as a push with sat=1 -> 1. Push with sat=1 while full -> vscr_sat unchanged.
//  T6 CR6/bypass: push cr6=4'b1000,cr6_en=1 -> cr6_out=1000; push cr6=0010,cr6_en=0 -> stays 1000.
//     With VSFX_WB_BYPASS_EN, empty FIFO, wb_ready=1 -> wb_valid in the same cycle, count stays 0.

Source files
------------

// File: rtl/vsfx_wb_if.sv
// vsfx_wb_if: vsfx result-capture bus plus the VR file write handshake.
// The slave modport is the writeback stage's view; master is the driving side.
interface vsfx_wb_if;
    logic         vrt_en;
    logic [127:0] vrt;
    logic [4:0]   vrt_addr;
    logic         sat;
    logic [3:0]   cr6;
    logic         cr6_en;
    logic         in_ready;
    logic         wb_valid;
    logic [4:0]   wb_addr;
    logic [127:0] wb_data;
    logic         wb_ready;

    modport master (
        output vrt_en, vrt, vrt_addr, sat, cr6, cr6_en, wb_ready,
        input  in_ready, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  vrt_en, vrt, vrt_addr, sat, cr6, cr6_en, wb_ready,
        output in_ready, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/vsfx_wb.sv
// vsfx_wb: queues vsfx results in a small FIFO and drains them to the VR file write port.
// Optional VSFX_WB_BYPASS_EN forwards a result straight to the write port when the FIFO is empty.
module vsfx_wb #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    vsfx_wb_if.slave   bus,
    input  logic       vscr_wr_en,
    input  logic       vscr_wr_sat,
    output logic       vscr_sat,
    output logic [3:0] cr6_out,
    output logic       ovf
);
    typedef struct packed {
        logic [4:0]   addr;
        logic [127:0] data;
    } entry_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          push_fifo;
    logic          pop_fifo;
    logic          bypass_take;

    // full comes from the registered count, so a same-cycle pop never frees a slot early
    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign bus.in_ready = !full;
    assign push         = bus.vrt_en & !full;
    assign head         = mem[rd_ptr];
    assign pop_fifo     = !empty & bus.wb_ready;
    assign push_fifo    = push & !bypass_take;

`ifdef VSFX_WB_BYPASS_EN
    logic bypass;
    assign bypass      = empty & bus.vrt_en & !rst;
    assign bypass_take = bypass & bus.wb_ready;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        if (!empty) begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = head.addr;
            bus.wb_data  = head.data;
        end else if (bypass) begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = bus.vrt_addr;
            bus.wb_data  = bus.vrt;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        if (!empty) begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = head.addr;
            bus.wb_data  = head.data;
        end
    end
`endif

    // NOTE: storage has no reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (!rst && push_fifo)
            mem[wr_ptr] <= {bus.vrt_addr, bus.vrt};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            vscr_sat <= 1'b0;
            cr6_out  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push_fifo)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_fifo)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_fifo && !pop_fifo)
                count <= count + 1'b1;
            else if (pop_fifo && !push_fifo)
                count <= count - 1'b1;
            // SAT/CR6 follow acceptance of the result, including a bypassed one
            vscr_sat <= (vscr_wr_en ? vscr_wr_sat : vscr_sat) | (push & bus.sat);
            if (push && bus.cr6_en)
                cr6_out <= bus.cr6;
            if (bus.vrt_en && full)
                ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vsfx_wb.sv
// tb_vsfx_wb: directed self-checking bench for vsfx_wb; inputs change on the falling edge
// and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_vsfx_wb;
    logic       clk = 1'b0;
    logic       rst;
    logic       vscr_wr_en;
    logic       vscr_wr_sat;
    logic       vscr_sat;
    logic [3:0] cr6_out;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    logic [4:0]   got_addr [16];
    logic [127:0] got_data [16];
    int           n_got;

    vsfx_wb_if bus();

    vsfx_wb #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .vscr_wr_en  (vscr_wr_en),
        .vscr_wr_sat (vscr_wr_sat),
        .vscr_sat    (vscr_sat),
        .cr6_out     (cr6_out),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic en, input logic [4:0] a, input logic [127:0] d,
                         input logic s, input logic [3:0] c, input logic ce, input logic rdy);
        bus.vrt_en   = en;
        bus.vrt_addr = a;
        bus.vrt      = d;
        bus.sat      = s;
        bus.cr6      = c;
        bus.cr6_en   = ce;
        bus.wb_ready = rdy;
    endtask

    // Let inputs settle, log a write accepted this cycle, then move to the next falling edge.
    task automatic step();
        #1;
        if (bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1 && n_got < 16) begin
            got_addr[n_got] = bus.wb_addr;
            got_data[n_got] = bus.wb_data;
            n_got++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vscr_wr_en  = 1'b0;
        vscr_wr_sat = 1'b0;
        drive(1'b1, 5'd9, {16{8'hAA}}, 1'b1, 4'hF, 1'b1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.wb_valid, bus.in_ready, vscr_sat, cr6_out, ovf, bus.wb_addr} !==
                {1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 5'd0}) begin
                errors++;
                $display("FAIL reset_flags: got %b want %b",
                         {bus.wb_valid, bus.in_ready, vscr_sat, cr6_out, ovf, bus.wb_addr},
                         {1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 5'd0});
            end
            checks++;
            if (bus.wb_data !== 128'd0) begin
                errors++;
                $display("FAIL reset_data: got %h want 0", bus.wb_data);
            end
        end
        rst = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (dut.count !== 3'd0 || bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got count=%0d valid=%b ready=%b want 0 0 1",
                     dut.count, bus.wb_valid, bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_ordering();
        logic [4:0]   ea [3] = '{5'd3, 5'd7, 5'd3};
        logic [127:0] ed [3] = '{{16{8'h11}}, {16{8'h22}}, {16{8'h33}}};
        n_got = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive(1'b1, ea[c], ed[c], 1'b0, 4'h0, 1'b0, 1'b1);
            else       drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
            step();
        end
        checks++;
        if (n_got !== 3) begin
            errors++;
            $display("FAIL order_count: got %0d writes want 3", n_got);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_addr[i] !== ea[i] || got_data[i] !== ed[i]) begin
                errors++;
                $display("FAIL order_entry%0d: got (%0d,%h) want (%0d,%h)",
                         i, got_addr[i], got_data[i], ea[i], ed[i]);
            end
        end
        #1;
        checks++;
        if (bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_empty: got wb_valid=%b want 0", bus.wb_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_full_ovf();
        n_got = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 5'(c + 1), {16{8'(8'h40 + c)}}, 1'b0, 4'h0, 1'b0, 1'b0);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_accept%0d: got in_ready=%b want 1", c, bus.in_ready);
            end
            @(negedge clk);
        end
        // Fifth push while full: dropped, flags sticky, SAT/CR6 untouched.
        drive(1'b1, 5'd5, {16{8'h44}}, 1'b1, 4'hF, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.wb_addr !== 5'd1) begin
            errors++;
            $display("FAIL full_ready: got in_ready=%b head=%0d want 0 1", bus.in_ready, bus.wb_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ovf, vscr_sat, cr6_out} !== {1'b1, 1'b0, 4'h0} || dut.count !== 3'd4) begin
            errors++;
            $display("FAIL full_drop: got ovf=%b sat=%b cr6=%h count=%0d want 1 0 0 4",
                     ovf, vscr_sat, cr6_out, dut.count);
        end
        // Pop and push together while full: the push is refused.
        drive(1'b1, 5'd6, {16{8'h66}}, 1'b0, 4'h0, 1'b0, 1'b1);
        step();
        drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || dut.count !== 3'd3) begin
            errors++;
            $display("FAIL full_popfree: got in_ready=%b count=%0d want 1 3", bus.in_ready, dut.count);
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
            step();
        end
        checks++;
        if (n_got !== 4) begin
            errors++;
            $display("FAIL full_drain_count: got %0d writes want 4", n_got);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_addr[i] !== 5'(i + 1) || got_data[i] !== {16{8'(8'h40 + i)}}) begin
                errors++;
                $display("FAIL full_drain%0d: got (%0d,%h) want (%0d,%h)",
                         i, got_addr[i], got_data[i], i + 1, {16{8'(8'h40 + i)}});
            end
        end
    endtask

    task automatic test_wrap();
        int max_count = 0;
        n_got = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 10) drive(1'b1, 5'(c + 16), {4{32'(c * 3 + 1)}}, 1'b0, 4'h0, 1'b0, 1'b1);
            else        drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
            #1;
            if (int'(dut.count) > max_count) max_count = int'(dut.count);
            step();
        end
        checks++;
        if (max_count > 1) begin
            errors++;
            $display("FAIL wrap_count: got max count %0d want <= 1", max_count);
        end
        checks++;
        if (n_got !== 10) begin
            errors++;
            $display("FAIL wrap_writes: got %0d writes want 10", n_got);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got_addr[i] !== 5'(i + 16) || got_data[i] !== {4{32'(i * 3 + 1)}}) begin
                errors++;
                $display("FAIL wrap_entry%0d: got (%0d,%h) want (%0d,%h)",
                         i, got_addr[i], got_data[i], i + 16, {4{32'(i * 3 + 1)}});
            end
        end
    endtask

    task automatic test_sat();
        drive(1'b1, 5'd1, {16{8'h5A}}, 1'b1, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (vscr_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_set: got %b want 1", vscr_sat);
        end
        drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
        vscr_wr_en  = 1'b1;
        vscr_wr_sat = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (vscr_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got %b want 0", vscr_sat);
        end
        drive(1'b1, 5'd2, {16{8'hA5}}, 1'b1, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (vscr_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear_and_push: got %b want 1", vscr_sat);
        end
        vscr_wr_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_cr6();
        drive(1'b1, 5'd4, {16{8'hC1}}, 1'b0, 4'b1000, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (cr6_out !== 4'b1000) begin
            errors++;
            $display("FAIL cr6_update: got %b want 1000", cr6_out);
        end
        drive(1'b1, 5'd5, {16{8'hC2}}, 1'b0, 4'b0010, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (cr6_out !== 4'b1000) begin
            errors++;
            $display("FAIL cr6_no_record: got %b want 1000", cr6_out);
        end
        drive(1'b0, 5'd6, {16{8'hC3}}, 1'b0, 4'b0101, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (cr6_out !== 4'b1000) begin
            errors++;
            $display("FAIL cr6_unqualified: got %b want 1000", cr6_out);
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd9, {16{8'hB9}}, 1'b0, 4'h0, 1'b0, 1'b1);
        #1;
        checks++;
`ifdef VSFX_WB_BYPASS_EN
        if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 5'd9 || bus.wb_data !== {16{8'hB9}}) begin
            errors++;
            $display("FAIL bypass_same_cycle: got (%b,%0d,%h) want (1,9,%h)",
                     bus.wb_valid, bus.wb_addr, bus.wb_data, {16{8'hB9}});
        end
`else
        if (bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL registered_latency: got wb_valid=%b want 0", bus.wb_valid);
        end
`endif
        @(negedge clk);
        drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
        #1;
        checks++;
`ifdef VSFX_WB_BYPASS_EN
        if (dut.count !== 3'd0 || bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_no_enqueue: got count=%0d valid=%b want 0 0", dut.count, bus.wb_valid);
        end
`else
        if (dut.count !== 3'd1 || bus.wb_valid !== 1'b1 || bus.wb_addr !== 5'd9) begin
            errors++;
            $display("FAIL registered_head: got count=%0d valid=%b addr=%0d want 1 1 9",
                     dut.count, bus.wb_valid, bus.wb_addr);
        end
`endif
        @(negedge clk);
        // Empty FIFO but write port stalled: the result must be queued.
        drive(1'b1, 5'd10, {16{8'hBA}}, 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (dut.count !== 3'd1 || bus.wb_valid !== 1'b1 || bus.wb_addr !== 5'd10 ||
            bus.wb_data !== {16{8'hBA}}) begin
            errors++;
            $display("FAIL stalled_enqueue: got count=%0d valid=%b addr=%0d want 1 1 10",
                     dut.count, bus.wb_valid, bus.wb_addr);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 5'd0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_ovf_reset();
        #1;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", ovf);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ovf !== 1'b0 || vscr_sat !== 1'b0 || cr6_out !== 4'h0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b sat=%b cr6=%h want 0 0 0", ovf, vscr_sat, cr6_out);
        end
    endtask

    initial begin
        n_got = 0;
        test_reset();
        test_ordering();
        test_full_ovf();
        test_wrap();
        test_sat();
        test_cr6();
        test_bypass();
        test_ovf_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
